stack_cpu_controller: RTL and testbench
=======================================

// Module: stack_cpu_controller
// PURPOSE
//  Multicycle Moore controller for the 8-bit stack processor datapath.
//  Consumes opcode (IR[7:5]) and drives every datapath control strobe: PC, memory, IR, stack, A/B, ALU muxes.
//  Sits directly upstream of the datapath. One instruction completes every 3-6 cycles.
// PARAMETERS
//  STACK_DEPTH  8  stack entries; used only by the depth guard (STACK_GUARD_EN)
// PORTS
//  clk          in   1  system clock, all state changes on rising edge
//  rst          in   1  synchronous, active-high reset
//  opcode       in   3  IR[7:5]; stable from DECODE until the next FETCH
//  pcWrite      out  1  unconditional PC load
//  pcWriteCond  out  1  PC load qualified by the datapath zero flag
//  pcSrc        out  1  0: PC <- ALU result, 1: PC <- IR[4:0]
//  IorD         out  1  0: memory address = PC, 1: memory address = IR[4:0]
//  memRead      out  1  memory read strobe
//  memWrite     out  1  memory write strobe; data = A
//  IRWrite      out  1  load IR
//  MtoS         out  1  stack input: 0 ALU register, 1 MDR
//  ldA, ldB     out  1  load A / B from stack output
//  srcA         out  1  ALU A: 0 reg A, 1 zero-extended PC
//  srcB         out  1  ALU B: 0 reg B, 1 constant 1
//  push, pop    out  1  stack push / pop strobes
//  tos          out  1  stack read-top without pop
//  ALUOp        out  2  00 add, 01 sub, 10 and, 11 not(A)
//  instr_done   out  1  one-cycle pulse in an instruction's last state
//  stk_err      out  1  sticky stack-guard error
//  state_dbg    out  4  current state encoding
// BEHAVIOUR
//  ISA opcodes: 000 ADD, 001 SUB, 010 AND, 011 NOT, 100 PUSH m, 101 POP m, 110 JMP a, 111 JZ a.
//  Outputs decode from the state register only (Moore). Any output not listed for a state is 0.
//  States/encoding and asserted outputs:
//   RST=0: all outputs 0 -> FETCH.
//   FETCH=1: memRead, IRWrite, srcA, srcB, ALUOp=00, pcWrite, pcSrc=0 -> DECODE.
//   DECODE=2: ADD/SUB/AND/NOT/POP -> POPA; PUSH -> MEMRD; JMP -> JUMP; JZ -> TOSRD.
//   POPA=3: pop, ldA -> POPB (ADD/SUB/AND), EXEC (NOT), MEMWR (POP).
//   POPB=4: pop, ldB -> EXEC.
//   EXEC=5: srcA=0, srcB=0, ALUOp=opcode[1:0] -> WBSTK.
//   WBSTK=6: MtoS=0, push, instr_done -> FETCH.
//   MEMRD=7: IorD, memRead (MDR captures) -> PUSHM.
//   PUSHM=8: MtoS=1, push, instr_done -> FETCH.
//   MEMWR=9: IorD, memWrite, instr_done -> FETCH.
//   JUMP=10: pcWrite, pcSrc=1, instr_done -> FETCH.
//   TOSRD=11: tos (zero reg captures TOS) -> BRZ.
//   BRZ=12: pcWriteCond, pcSrc=1, instr_done -> FETCH.
//   HALT=13: all strobes 0; terminal until rst.
//  Latency in cycles: ADD/SUB/AND 6, NOT 5, PUSH 4, POP 4, JMP 3, JZ 4.
//  Reset:
//   - rst high in any cycle forces state=RST next edge, even mid-instruction.
//   - In-flight instruction is abandoned. stk_err and the depth counter clear.
//  Unused encodings 14-15 -> RST next cycle, all outputs 0.
//  Mutual exclusion, never asserted together in one cycle:
//   - push and pop
//   - memRead and memWrite
//   - pcWrite and pcWriteCond
// CONFIGURATION
//  STACK_GUARD_EN defined:
//   - Depth counter 0..STACK_DEPTH, +1 on push, -1 on pop, cleared by rst.
//   - In DECODE, the FSM goes to HALT and sets stk_err=1 if:
//     - ADD/SUB/AND and depth<2, or
//     - NOT/POP/JZ and depth<1, or
//     - PUSH and depth==STACK_DEPTH.
//   - HALT is entered instead of the normal next state; no strobe issues that cycle.
//  STACK_GUARD_EN undefined: no counter, stk_err tied 0, HALT unreachable.
// TESTING
//  rst high 2 cycles then low -> state_dbg 0 then 1; all strobes 0 while in RST.
//  opcode=000 after reset -> state_dbg 1,2,3,4,5,6; ALUOp=00 in EXEC; push in cycle 6; instr_done pulses once.
//  opcode=100 -> FETCH, DECODE, MEMRD (IorD=1, memRead=1), PUSHM (MtoS=1, push=1); 4 cycles.
//  opcode=111 -> tos in TOSRD, pcWriteCond=1 and pcSrc=1 in BRZ; pcWrite=0 throughout BRZ.
//  rst asserted during POPB of SUB -> next state RST, no push issued; FETCH follows.
//  STACK_GUARD_EN: ADD with depth 1 -> HALT (13), stk_err=1; held until rst.

Source files
------------

// File: rtl/stack_cpu_controller.sv
// Multicycle Moore controller for the 8-bit stack processor datapath.
// Optional depth guard enabled by defining STACK_GUARD_EN.
module stack_cpu_controller #(
  parameter int STACK_DEPTH = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [2:0] opcode,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       pcSrc,
  output logic       IorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       IRWrite,
  output logic       MtoS,
  output logic       ldA,
  output logic       ldB,
  output logic       srcA,
  output logic       srcB,
  output logic       push,
  output logic       pop,
  output logic       tos,
  output logic [1:0] ALUOp,
  output logic       instr_done,
  output logic       stk_err,
  output logic [3:0] state_dbg
);

  typedef enum logic [3:0] {
    S_RST    = 4'd0,  S_FETCH = 4'd1,  S_DECODE = 4'd2,  S_POPA  = 4'd3,
    S_POPB   = 4'd4,  S_EXEC  = 4'd5,  S_WBSTK  = 4'd6,  S_MEMRD = 4'd7,
    S_PUSHM  = 4'd8,  S_MEMWR = 4'd9,  S_JUMP   = 4'd10, S_TOSRD = 4'd11,
    S_BRZ    = 4'd12, S_HALT  = 4'd13
  } state_t;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_NOT = 3'd3,
    OP_PUSH = 3'd4, OP_POP = 3'd5, OP_JMP = 3'd6, OP_JZ = 3'd7
  } op_t;

  typedef struct packed {
    logic pcWrite, pcWriteCond, pcSrc, IorD, memRead, memWrite, IRWrite, MtoS;
    logic ldA, ldB, srcA, srcB, push, pop, tos;
    logic [1:0] ALUOp;
    logic instr_done;
  } ctl_t;

  state_t state, nxt;
  ctl_t   ctl;
  op_t    op;
  logic   guard_trip;

  assign op = op_t'(opcode);

  function automatic ctl_t decode(state_t s, logic [1:0] aluop);
    ctl_t c;
    c = '0;
    case (s)
      S_FETCH: begin
        c.memRead = 1'b1; c.IRWrite = 1'b1; c.srcA = 1'b1; c.srcB = 1'b1;
        c.pcWrite = 1'b1;
      end
      S_POPA:  begin c.pop = 1'b1; c.ldA = 1'b1; end
      S_POPB:  begin c.pop = 1'b1; c.ldB = 1'b1; end
      S_EXEC:  c.ALUOp = aluop;
      S_WBSTK: begin c.push = 1'b1; c.instr_done = 1'b1; end
      S_MEMRD: begin c.IorD = 1'b1; c.memRead = 1'b1; end
      S_PUSHM: begin c.MtoS = 1'b1; c.push = 1'b1; c.instr_done = 1'b1; end
      S_MEMWR: begin c.IorD = 1'b1; c.memWrite = 1'b1; c.instr_done = 1'b1; end
      S_JUMP:  begin c.pcWrite = 1'b1; c.pcSrc = 1'b1; c.instr_done = 1'b1; end
      S_TOSRD: c.tos = 1'b1;
      S_BRZ:   begin c.pcWriteCond = 1'b1; c.pcSrc = 1'b1; c.instr_done = 1'b1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  always_comb begin
    nxt = S_RST;
    case (state)
      S_RST:    nxt = S_FETCH;
      S_FETCH:  nxt = S_DECODE;
      S_DECODE: begin
        if (guard_trip) nxt = S_HALT;
        else begin
          case (op)
            OP_PUSH: nxt = S_MEMRD;
            OP_JMP:  nxt = S_JUMP;
            OP_JZ:   nxt = S_TOSRD;
            default: nxt = S_POPA;
          endcase
        end
      end
      S_POPA: begin
        case (op)
          OP_NOT:  nxt = S_EXEC;
          OP_POP:  nxt = S_MEMWR;
          default: nxt = S_POPB;
        endcase
      end
      S_POPB:  nxt = S_EXEC;
      S_EXEC:  nxt = S_WBSTK;
      S_MEMRD: nxt = S_PUSHM;
      S_TOSRD: nxt = S_BRZ;
      S_WBSTK, S_PUSHM, S_MEMWR, S_JUMP, S_BRZ: nxt = S_FETCH;
      S_HALT:  nxt = S_HALT;
      default: nxt = S_RST;
    endcase
  end

  // Strobes are registered from the next state so they line up with the state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_RST;
      ctl   <= '0;
    end else begin
      state <= nxt;
      ctl   <= decode(nxt, opcode[1:0]);
    end
  end

`ifdef STACK_GUARD_EN
  localparam int DW = $clog2(STACK_DEPTH + 1);

  logic [DW-1:0] depth;
  logic          err_q;

  always_comb begin
    guard_trip = 1'b0;
    if (state == S_DECODE) begin
      case (op)
        OP_ADD, OP_SUB, OP_AND: guard_trip = (depth < DW'(2));
        OP_NOT, OP_POP, OP_JZ:  guard_trip = (depth == '0);
        OP_PUSH:                guard_trip = (depth == DW'(STACK_DEPTH));
        default:                guard_trip = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      depth <= '0;
      err_q <= 1'b0;
    end else begin
      if (ctl.push && !ctl.pop && depth != DW'(STACK_DEPTH)) depth <= depth + DW'(1);
      else if (ctl.pop && !ctl.push && depth != '0)          depth <= depth - DW'(1);
      if (guard_trip) err_q <= 1'b1;
    end
  end

  assign stk_err = err_q;
`else
  assign guard_trip = 1'b0;
  assign stk_err    = 1'b0;
`endif

  assign pcWrite     = ctl.pcWrite;
  assign pcWriteCond = ctl.pcWriteCond;
  assign pcSrc       = ctl.pcSrc;
  assign IorD        = ctl.IorD;
  assign memRead     = ctl.memRead;
  assign memWrite    = ctl.memWrite;
  assign IRWrite     = ctl.IRWrite;
  assign MtoS        = ctl.MtoS;
  assign ldA         = ctl.ldA;
  assign ldB         = ctl.ldB;
  assign srcA        = ctl.srcA;
  assign srcB        = ctl.srcB;
  assign push        = ctl.push;
  assign pop         = ctl.pop;
  assign tos         = ctl.tos;
  assign ALUOp       = ctl.ALUOp;
  assign instr_done  = ctl.instr_done;
  assign state_dbg   = state;

endmodule

// File: tb/tb_stack_cpu_controller.sv
// Testbench for stack_cpu_controller: directed vector table, reset/halt corner
// sequences, and random instruction streams checked against an ISA-level model.
module tb_stack_cpu_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] opcode;
  logic       pcWrite, pcWriteCond, pcSrc, IorD, memRead, memWrite, IRWrite, MtoS;
  logic       ldA, ldB, srcA, srcB, push, pop, tos, instr_done, stk_err;
  logic [1:0] ALUOp;
  logic [3:0] state_dbg;

  stack_cpu_controller #(.STACK_DEPTH(8)) dut (
    .clk(clk), .rst(rst), .opcode(opcode),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .pcSrc(pcSrc), .IorD(IorD),
    .memRead(memRead), .memWrite(memWrite), .IRWrite(IRWrite), .MtoS(MtoS),
    .ldA(ldA), .ldB(ldB), .srcA(srcA), .srcB(srcB), .push(push), .pop(pop),
    .tos(tos), .ALUOp(ALUOp), .instr_done(instr_done), .stk_err(stk_err),
    .state_dbg(state_dbg)
  );

  always #5 clk = ~clk;

`ifdef STACK_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  typedef struct packed {
    logic pcWrite, pcWriteCond, pcSrc, IorD, memRead, memWrite, IRWrite, MtoS;
    logic ldA, ldB, srcA, srcB, push, pop, tos;
    logic [1:0] ALUOp;
    logic instr_done;
  } ctl_t;

  typedef struct packed {
    logic [2:0]      op;
    logic [3:0]      len;
    logic [7:0][3:0] seq;
  } vec_t;

  ctl_t act;
  assign act = {pcWrite, pcWriteCond, pcSrc, IorD, memRead, memWrite, IRWrite, MtoS,
                ldA, ldB, srcA, srcB, push, pop, tos, ALUOp, instr_done};

  int   checks = 0;
  int   errors = 0;
  int   depth_m = 0;
  logic err_m = 1'b0;

  function automatic ctl_t exp_out(int st, logic [2:0] op);
    ctl_t c;
    c = '0;
    case (st)
      1:  begin c.memRead = 1; c.IRWrite = 1; c.srcA = 1; c.srcB = 1; c.pcWrite = 1; end
      3:  begin c.pop = 1; c.ldA = 1; end
      4:  begin c.pop = 1; c.ldB = 1; end
      5:  c.ALUOp = op[1:0];
      6:  begin c.push = 1; c.instr_done = 1; end
      7:  begin c.IorD = 1; c.memRead = 1; end
      8:  begin c.MtoS = 1; c.push = 1; c.instr_done = 1; end
      9:  begin c.IorD = 1; c.memWrite = 1; c.instr_done = 1; end
      10: begin c.pcWrite = 1; c.pcSrc = 1; c.instr_done = 1; end
      11: c.tos = 1;
      12: begin c.pcWriteCond = 1; c.pcSrc = 1; c.instr_done = 1; end
      default: c = '0;
    endcase
    return c;
  endfunction

  // Net stack effect of a completed instruction.
  function automatic int delta(logic [2:0] op);
    case (op)
      3'd0, 3'd1, 3'd2, 3'd5: return -1;
      3'd4:                   return 1;
      default:                return 0;
    endcase
  endfunction

  function automatic bit would_halt(logic [2:0] op, int depth);
    if (!GUARD) return 1'b0;
    case (op)
      3'd0, 3'd1, 3'd2:       return depth < 2;
      3'd3, 3'd5, 3'd7:       return depth < 1;
      3'd4:                   return depth == 8;
      default:                return 1'b0;
    endcase
  endfunction

  // ISA-level model: fetch, decode, one pop state per operand, then the op's tail.
  task automatic build(input logic [2:0] op, output int len, output logic [7:0][3:0] seq,
                       output bit halt);
    seq = '0; seq[0] = 4'd1; seq[1] = 4'd2; len = 2;
    halt = would_halt(op, depth_m);
    if (halt) begin
      seq[2] = 4'd13; seq[3] = 4'd13; seq[4] = 4'd13; len = 5;
    end else begin
      case (op)
        3'd0, 3'd1, 3'd2: begin seq[2] = 4'd3; seq[3] = 4'd4; seq[4] = 4'd5; seq[5] = 4'd6; len = 6; end
        3'd3: begin seq[2] = 4'd3; seq[3] = 4'd5; seq[4] = 4'd6; len = 5; end
        3'd4: begin seq[2] = 4'd7; seq[3] = 4'd8; len = 4; end
        3'd5: begin seq[2] = 4'd3; seq[3] = 4'd9; len = 4; end
        3'd6: begin seq[2] = 4'd10; len = 3; end
        default: begin seq[2] = 4'd11; seq[3] = 4'd12; len = 4; end
      endcase
    end
  endtask

  task automatic chk(input string name, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s t=%0t got %0h want %0h", name, $time, a, e);
    end
  endtask

  task automatic check_state(input int st);
    chk("state_dbg", int'(state_dbg), st);
    chk("strobes", int'(act), int'(exp_out(st, opcode)));
    chk("stk_err", int'(stk_err), int'(err_m));
  endtask

  task automatic reset_tail();
    rst = 1'b1;
    @(negedge clk);
    depth_m = 0;
    err_m = 1'b0;
    check_state(0);
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Entered at the negedge where FETCH is expected; leaves at the next FETCH.
  task automatic run_seq(input logic [2:0] op, input int len, input logic [7:0][3:0] seq,
                         input int abort_at);
    for (int i = 0; i < len; i++) begin
      if (i == 0) opcode = op;
      if (seq[i] == 4'd13) err_m = 1'b1;
      check_state(int'(seq[i]));
      if (i == abort_at) begin
        reset_tail();
        return;
      end
      @(negedge clk);
    end
    depth_m += delta(op);
  endtask

  vec_t vecs[11];

  initial begin
    int len, ab;
    bit halt;
    logic [2:0] op;
    logic [7:0][3:0] seq;

    vecs[0]  = '{op: 3'd4, len: 4'd4, seq: 32'h0000_8721};
    vecs[1]  = '{op: 3'd4, len: 4'd4, seq: 32'h0000_8721};
    vecs[2]  = '{op: 3'd4, len: 4'd4, seq: 32'h0000_8721};
    vecs[3]  = '{op: 3'd4, len: 4'd4, seq: 32'h0000_8721};
    vecs[4]  = '{op: 3'd0, len: 4'd6, seq: 32'h0065_4321};
    vecs[5]  = '{op: 3'd1, len: 4'd6, seq: 32'h0065_4321};
    vecs[6]  = '{op: 3'd3, len: 4'd5, seq: 32'h0006_5321};
    vecs[7]  = '{op: 3'd7, len: 4'd4, seq: 32'h0000_CB21};
    vecs[8]  = '{op: 3'd6, len: 4'd3, seq: 32'h0000_0A21};
    vecs[9]  = '{op: 3'd2, len: 4'd6, seq: 32'h0065_4321};
    vecs[10] = '{op: 3'd5, len: 4'd4, seq: 32'h0000_9321};

    rst = 1'b1;
    opcode = 3'd0;
    @(negedge clk);
    check_state(0);
    @(negedge clk);
    check_state(0);
    rst = 1'b0;
    @(negedge clk);

    for (int v = 0; v < 11; v++)
      run_seq(vecs[v].op, int'(vecs[v].len), vecs[v].seq, -1);

    // Reset during POPB of SUB: no push, RST then FETCH.
    run_seq(3'd1, 6, 32'h0065_4321, 3);

`ifdef STACK_GUARD_EN
    // ADD with only one entry on the stack halts and stays halted until reset.
    run_seq(3'd4, 4, 32'h0000_8721, -1);
    run_seq(3'd0, 5, 32'h000D_DD21, 4);
`endif

    for (int n = 0; n < 120; n++) begin
      op = 3'($urandom_range(0, 7));
      build(op, len, seq, halt);
      if (halt) ab = len - 1;
      else if ($urandom_range(0, 7) == 0) ab = int'($urandom_range(0, len - 1));
      else ab = -1;
      run_seq(op, len, seq, ab);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t got running want finished", $time);
    $fatal(1);
  end

endmodule
